// File: rtl/cmd_spi_rx.sv
// SPI command receiver: collects opcode/payload/checksum frames from an MCU and
// commits validated DDS command or system-time words into output registers.
module cmd_spi_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        SCK,
    input  logic        CS_N,
    input  logic        MOSI,
    output logic [47:0] FREQ,
    output logic [47:0] FREQ_STEP,
    output logic [31:0] FREQ_RATE,
    output logic [63:0] TIME_START,
    output logic [15:0] N_impulse,
    output logic [1:0]  TYPE_impulse,
    output logic [31:0] Interval_Ti,
    output logic [31:0] Interval_Tp,
    output logic [31:0] Tblank1,
    output logic [31:0] Tblank2,
    output logic        SPI_WR,
    output logic [63:0] SYS_TIME,
    output logic        SYS_TIME_UPDATE,
    output logic        FRAME_ERR,
    output logic        BUSY
);

    localparam logic [7:0] OP_CMD   = 8'hA5;
    localparam logic [7:0] OP_TIME  = 8'h5A;
    localparam logic [5:0] CMD_LEN  = 6'd43;
    localparam logic [5:0] TIME_LEN = 6'd9;

    typedef enum logic [2:0] {IDLE, OPCODE, PAYLOAD, CHECK, SKIP} state_t;

    logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
    logic                   sck_prev, cs_prev;
    logic                   sck_s, cs_s, mosi_s;
    logic                   sck_rise, cs_rise, cs_fall;

    state_t       state;
    logic [2:0]   bit_cnt;
    logic [5:0]   byte_cnt;
    logic [7:0]   shift;
    logic [7:0]   xor_acc;
    logic [7:0]   rx_byte;
    logic         is_time;
    logic [5:0]   payload_len;
    logic [343:0] shadow;

    // Chains reset low so a CS_N already held low after reset never looks like a falling edge.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sck_sync  <= '0;
            cs_sync   <= '0;
            mosi_sync <= '0;
            sck_prev  <= 1'b0;
            cs_prev   <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], SCK};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], CS_N};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
            sck_prev  <= sck_s;
            cs_prev   <= cs_s;
        end
    end

    assign sck_s       = sck_sync[SYNC_STAGES-1];
    assign cs_s        = cs_sync[SYNC_STAGES-1];
    assign mosi_s      = mosi_sync[SYNC_STAGES-1];
    assign sck_rise    = sck_s & ~sck_prev;
    assign cs_rise     = cs_s & ~cs_prev;
    assign cs_fall     = ~cs_s & cs_prev;
    assign rx_byte     = {shift[6:0], mosi_s};
    assign payload_len = is_time ? TIME_LEN : CMD_LEN;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state           <= IDLE;
            bit_cnt         <= '0;
            byte_cnt        <= '0;
            shift           <= '0;
            xor_acc         <= '0;
            is_time         <= 1'b0;
            shadow          <= '0;
            FREQ            <= '0;
            FREQ_STEP       <= '0;
            FREQ_RATE       <= '0;
            TIME_START      <= '0;
            N_impulse       <= '0;
            TYPE_impulse    <= '0;
            Interval_Ti     <= '0;
            Interval_Tp     <= '0;
            Tblank1         <= '0;
            Tblank2         <= '0;
            SPI_WR          <= 1'b0;
            SYS_TIME        <= '0;
            SYS_TIME_UPDATE <= 1'b0;
            FRAME_ERR       <= 1'b0;
            BUSY            <= 1'b0;
        end else begin
            SPI_WR    <= 1'b0;
            FRAME_ERR <= 1'b0;
            if (state == IDLE) begin
                if (cs_fall) begin
                    state    <= OPCODE;
                    bit_cnt  <= '0;
                    byte_cnt <= '0;
                    xor_acc  <= '0;
                    BUSY     <= 1'b1;
                end
            end else if (cs_rise) begin
                // Early deselect is an error only once at least one bit of a live frame arrived.
                state <= IDLE;
                BUSY  <= 1'b0;
                if (state == PAYLOAD || state == CHECK || (state == OPCODE && bit_cnt != 3'd0))
                    FRAME_ERR <= 1'b1;
            end else if (sck_rise) begin
                bit_cnt <= bit_cnt + 3'd1;
                shift   <= rx_byte;
                if (bit_cnt == 3'd7) begin
                    if (byte_cnt != 6'h3F)
                        byte_cnt <= byte_cnt + 6'd1;
                    xor_acc <= xor_acc ^ rx_byte;
                    case (state)
                        OPCODE: begin
                            if (rx_byte == OP_CMD || rx_byte == OP_TIME) begin
                                is_time <= (rx_byte == OP_TIME);
                                state   <= PAYLOAD;
                            end else begin
                                state     <= SKIP;
                                FRAME_ERR <= 1'b1;
                            end
                        end
                        PAYLOAD: begin
                            shadow <= {shadow[335:0], rx_byte};
                            if (byte_cnt == payload_len)
                                state <= CHECK;
                        end
                        CHECK: begin
                            state <= SKIP;
                            if ((xor_acc ^ rx_byte) == 8'h00) begin
                                if (is_time) begin
                                    SYS_TIME        <= shadow[71:8];
                                    SYS_TIME_UPDATE <= shadow[0];
                                end else begin
                                    FREQ         <= shadow[343:296];
                                    FREQ_STEP    <= shadow[295:248];
                                    FREQ_RATE    <= shadow[247:216];
                                    TIME_START   <= shadow[215:152];
                                    N_impulse    <= shadow[151:136];
                                    TYPE_impulse <= shadow[129:128];
                                    Interval_Ti  <= shadow[127:96];
                                    Interval_Tp  <= shadow[95:64];
                                    Tblank1      <= shadow[63:32];
                                    Tblank2      <= shadow[31:0];
                                    SPI_WR       <= 1'b1;
                                end
                            end else begin
                                FRAME_ERR <= 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_cmd_spi_rx.sv
// Bench for cmd_spi_rx: drives SPI mode-0 frames and compares the outputs with a
// frame-level model of which frames commit and what they carry.
module tb_cmd_spi_rx;

    typedef struct packed {
        logic [47:0] freq;
        logic [47:0] step;
        logic [31:0] rate;
        logic [63:0] tstart;
        logic [15:0] n;
        logic [7:0]  typ;
        logic [31:0] ti;
        logic [31:0] tp;
        logic [31:0] tb1;
        logic [31:0] tb2;
    } cmd_t;

    logic CLK = 1'b0, RESET = 1'b1, SCK = 1'b0, CS_N = 1'b1, MOSI = 1'b0;
    logic [47:0] FREQ, FREQ_STEP;
    logic [31:0] FREQ_RATE, Interval_Ti, Interval_Tp, Tblank1, Tblank2;
    logic [63:0] TIME_START, SYS_TIME;
    logic [15:0] N_impulse;
    logic [1:0]  TYPE_impulse;
    logic        SPI_WR, SYS_TIME_UPDATE, FRAME_ERR, BUSY;

    cmd_spi_rx #(.SYNC_STAGES(2)) dut (
        .CLK(CLK), .RESET(RESET), .SCK(SCK), .CS_N(CS_N), .MOSI(MOSI),
        .FREQ(FREQ), .FREQ_STEP(FREQ_STEP), .FREQ_RATE(FREQ_RATE),
        .TIME_START(TIME_START), .N_impulse(N_impulse), .TYPE_impulse(TYPE_impulse),
        .Interval_Ti(Interval_Ti), .Interval_Tp(Interval_Tp),
        .Tblank1(Tblank1), .Tblank2(Tblank2), .SPI_WR(SPI_WR),
        .SYS_TIME(SYS_TIME), .SYS_TIME_UPDATE(SYS_TIME_UPDATE),
        .FRAME_ERR(FRAME_ERR), .BUSY(BUSY)
    );

    always #10 CLK = ~CLK;

    int checks = 0, passed = 0;
    int wr_cnt = 0, err_cnt = 0;
    logic [402:0] wr_snap = '0;
    logic [7:0] tx[$];
    int bitpos = 0;

    cmd_t        exp_c = '0;
    logic [63:0] exp_time = '0;
    logic        exp_upd = 1'b0;

    function automatic logic [402:0] got_fields();
        return {FREQ, FREQ_STEP, FREQ_RATE, TIME_START, N_impulse, TYPE_impulse,
                Interval_Ti, Interval_Tp, Tblank1, Tblank2, SYS_TIME, SYS_TIME_UPDATE};
    endfunction

    function automatic logic [402:0] exp_fields();
        return {exp_c.freq, exp_c.step, exp_c.rate, exp_c.tstart, exp_c.n, exp_c.typ[1:0],
                exp_c.ti, exp_c.tp, exp_c.tb1, exp_c.tb2, exp_time, exp_upd};
    endfunction

    // Pulse monitor: counts high cycles and snapshots the outputs during SPI_WR.
    always @(negedge CLK) begin
        if (SPI_WR) begin
            wr_cnt  = wr_cnt + 1;
            wr_snap = got_fields();
        end
        if (FRAME_ERR) err_cnt = err_cnt + 1;
    end

    task automatic push_be(input logic [63:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) tx.push_back(v[8*i +: 8]);
    endtask

    task automatic add_checksum();
        logic [7:0] x;
        x = 8'h00;
        foreach (tx[i]) x ^= tx[i];
        tx.push_back(x);
    endtask

    task automatic make_cmd(input cmd_t c);
        tx.delete();
        tx.push_back(8'hA5);
        push_be(c.freq, 6);  push_be(c.step, 6); push_be(c.rate, 4); push_be(c.tstart, 8);
        push_be(c.n, 2);     push_be(c.typ, 1);  push_be(c.ti, 4);   push_be(c.tp, 4);
        push_be(c.tb1, 4);   push_be(c.tb2, 4);
        add_checksum();
    endtask

    task automatic make_time(input logic [63:0] t, input logic [7:0] flags);
        tx.delete();
        tx.push_back(8'h5A);
        push_be(t, 8);
        tx.push_back(flags);
        add_checksum();
    endtask

    function automatic cmd_t rand_cmd();
        cmd_t c;
        c.freq = {$urandom, $urandom}; c.step = {$urandom, $urandom};
        c.rate = $urandom; c.tstart = {$urandom, $urandom}; c.n = 16'($urandom);
        c.typ = 8'($urandom); c.ti = $urandom; c.tp = $urandom;
        c.tb1 = $urandom; c.tb2 = $urandom;
        return c;
    endfunction

    task automatic begin_frame();
        @(negedge CLK);
        CS_N = 1'b0;
        bitpos = 0;
        repeat (4) @(negedge CLK);
    endtask

    // One SCK period is 8 CLK (the fastest allowed rate); MOSI changes while SCK is low.
    task automatic send_bits(input int n);
        for (int i = 0; i < n; i++) begin
            logic [7:0] b;
            b = tx[bitpos / 8];
            MOSI = b[7 - (bitpos % 8)];
            bitpos++;
            repeat (4) @(negedge CLK);
            SCK = 1'b1;
            repeat (4) @(negedge CLK);
            SCK = 1'b0;
        end
    endtask

    task automatic end_frame(input int gap);
        repeat (4) @(negedge CLK);
        CS_N = 1'b1;
        MOSI = 1'b0;
        repeat (gap) @(negedge CLK);
    endtask

    task automatic send_all();
        begin_frame();
        send_bits(tx.size() * 8);
        end_frame(12);
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        repeat (3) @(negedge CLK);
        checks++;
        if (got_fields() !== '0) $display("FAIL reset_fields: got %h required 0", got_fields());
        else passed++;
        checks++;
        if ({SPI_WR, FRAME_ERR, BUSY} !== 3'b000)
            $display("FAIL reset_flags: got %b required 000", {SPI_WR, FRAME_ERR, BUSY});
        else passed++;
        RESET = 1'b0;
        repeat (6) @(negedge CLK);
        checks++;
        if ({got_fields(), BUSY} !== '0) $display("FAIL after_reset_idle: got %h required 0", {got_fields(), BUSY});
        else passed++;
    endtask

    task automatic test_cmd_frame();
        cmd_t c;
        int w0, e0;
        c = '{freq: 48'd43980465111040, step: 48'd2932031, rate: 32'd1, tstart: 64'd48000,
              n: 16'd1000, typ: 8'd0, ti: 32'd4800, tp: 32'd4800, tb1: 32'd480, tb2: 32'd480};
        w0 = wr_cnt; e0 = err_cnt;
        make_cmd(c);
        begin_frame();
        send_bits(44 * 8);
        checks++;
        if (got_fields() !== exp_fields()) $display("FAIL hold_during_rx: got %h required %h", got_fields(), exp_fields());
        else passed++;
        checks++;
        if (BUSY !== 1'b1) $display("FAIL busy_in_frame: got %b required 1", BUSY);
        else passed++;
        send_bits(8);
        end_frame(12);
        exp_c = c;
        checks++;
        if (wr_cnt - w0 != 1) $display("FAIL cmd_spi_wr_cycles: got %0d required 1", wr_cnt - w0);
        else passed++;
        checks++;
        if (wr_snap !== exp_fields()) $display("FAIL cmd_fields_at_wr: got %h required %h", wr_snap, exp_fields());
        else passed++;
        checks++;
        if (got_fields() !== exp_fields()) $display("FAIL cmd_fields: got %h required %h", got_fields(), exp_fields());
        else passed++;
        checks++;
        if (err_cnt != e0) $display("FAIL cmd_no_err: got %0d required %0d", err_cnt, e0);
        else passed++;
    endtask

    task automatic test_bad_checksum();
        cmd_t c;
        int w0, e0;
        for (int k = 0; k < 2; k++) begin
            c = exp_c;
            if (k == 1) begin c.freq = c.freq + 48'd1; c.n = 16'd7; end
            w0 = wr_cnt; e0 = err_cnt;
            make_cmd(c);
            tx[tx.size() - 1] ^= 8'h01;
            send_all();
            checks++;
            if (err_cnt - e0 != 1) $display("FAIL badsum_err_cycles: got %0d required 1", err_cnt - e0);
            else passed++;
            checks++;
            if (wr_cnt != w0) $display("FAIL badsum_no_wr: got %0d required %0d", wr_cnt, w0);
            else passed++;
            checks++;
            if (got_fields() !== exp_fields()) $display("FAIL badsum_hold: got %h required %h", got_fields(), exp_fields());
            else passed++;
        end
    endtask

    task automatic test_time_frame();
        int w0, e0;
        logic [7:0] flags [2];
        flags[0] = 8'h01; flags[1] = 8'h00;
        for (int k = 0; k < 2; k++) begin
            w0 = wr_cnt; e0 = err_cnt;
            make_time(64'd1000, flags[k]);
            send_all();
            exp_time = 64'd1000;
            exp_upd  = flags[k][0];
            checks++;
            if (got_fields() !== exp_fields()) $display("FAIL time_fields: got %h required %h", got_fields(), exp_fields());
            else passed++;
            checks++;
            if (wr_cnt != w0 || err_cnt != e0)
                $display("FAIL time_pulses: got wr %0d err %0d required 0 0", wr_cnt - w0, err_cnt - e0);
            else passed++;
        end
    endtask

    task automatic test_abort();
        cmd_t c;
        int w0, e0;
        e0 = err_cnt;
        begin_frame();
        checks++;
        if (BUSY !== 1'b1) $display("FAIL empty_frame_busy: got %b required 1", BUSY);
        else passed++;
        end_frame(12);
        checks++;
        if (err_cnt != e0 || BUSY !== 1'b0)
            $display("FAIL empty_frame: got err %0d busy %b required 0 0", err_cnt - e0, BUSY);
        else passed++;
        c = rand_cmd();
        w0 = wr_cnt; e0 = err_cnt;
        make_cmd(c);
        begin_frame();
        send_bits(20 * 8);
        end_frame(12);
        checks++;
        if (err_cnt - e0 != 1 || wr_cnt != w0)
            $display("FAIL abort_pulses: got err %0d wr %0d required 1 0", err_cnt - e0, wr_cnt - w0);
        else passed++;
        checks++;
        if (got_fields() !== exp_fields()) $display("FAIL abort_hold: got %h required %h", got_fields(), exp_fields());
        else passed++;
        send_all();
        exp_c = c;
        checks++;
        if (err_cnt - e0 != 1 || wr_cnt - w0 != 1)
            $display("FAIL abort_then_valid: got err %0d wr %0d required 1 1", err_cnt - e0, wr_cnt - w0);
        else passed++;
        checks++;
        if (got_fields() !== exp_fields()) $display("FAIL abort_then_valid_fields: got %h required %h", got_fields(), exp_fields());
        else passed++;
    endtask

    task automatic test_unknown_opcode();
        int w0, e0;
        tx.delete();
        tx.push_back(8'h33);
        for (int i = 0; i < 10; i++) tx.push_back(8'($urandom));
        w0 = wr_cnt; e0 = err_cnt;
        begin_frame();
        send_bits(8);
        checks++;
        if (err_cnt - e0 != 1) $display("FAIL unk_err_at_opcode: got %0d required 1", err_cnt - e0);
        else passed++;
        send_bits(80);
        checks++;
        if (BUSY !== 1'b1) $display("FAIL unk_busy_held: got %b required 1", BUSY);
        else passed++;
        end_frame(12);
        checks++;
        if (BUSY !== 1'b0) $display("FAIL unk_busy_drop: got %b required 0", BUSY);
        else passed++;
        checks++;
        if (err_cnt - e0 != 1 || wr_cnt != w0)
            $display("FAIL unk_pulses: got err %0d wr %0d required 1 0", err_cnt - e0, wr_cnt - w0);
        else passed++;
        checks++;
        if (got_fields() !== exp_fields()) $display("FAIL unk_hold: got %h required %h", got_fields(), exp_fields());
        else passed++;
    endtask

    task automatic test_reset_mid_frame();
        cmd_t c;
        int w0, e0;
        c = rand_cmd();
        make_cmd(c);
        w0 = wr_cnt; e0 = err_cnt;
        begin_frame();
        send_bits(30 * 8);
        @(negedge CLK);
        RESET = 1'b1;
        #1;
        checks++;
        if ({got_fields(), SPI_WR, FRAME_ERR, BUSY} !== '0)
            $display("FAIL reset_mid_frame: got %h required 0", {got_fields(), SPI_WR, FRAME_ERR, BUSY});
        else passed++;
        exp_c = '0; exp_time = '0; exp_upd = 1'b0;
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        repeat (4) @(negedge CLK);
        send_bits(15 * 8);
        end_frame(12);
        checks++;
        if (err_cnt != e0 || wr_cnt != w0 || got_fields() !== '0)
            $display("FAIL reset_discard: got err %0d wr %0d fields %h required 0 0 0",
                     err_cnt - e0, wr_cnt - w0, got_fields());
        else passed++;
        send_all();
        exp_c = c;
        checks++;
        if (wr_cnt - w0 != 1 || got_fields() !== exp_fields())
            $display("FAIL reset_then_valid: got wr %0d fields %h required 1 %h", wr_cnt - w0, got_fields(), exp_fields());
        else passed++;
    endtask

    task automatic test_back_to_back();
        cmd_t a, b;
        int w0, e0;
        a = rand_cmd(); b = rand_cmd();
        w0 = wr_cnt; e0 = err_cnt;
        make_cmd(a);
        begin_frame(); send_bits(tx.size() * 8); end_frame(7);
        make_cmd(b);
        begin_frame(); send_bits(tx.size() * 8); end_frame(12);
        exp_c = b;
        checks++;
        if (wr_cnt - w0 != 2 || err_cnt != e0)
            $display("FAIL b2b_pulses: got wr %0d err %0d required 2 0", wr_cnt - w0, err_cnt - e0);
        else passed++;
        checks++;
        if (got_fields() !== exp_fields()) $display("FAIL b2b_fields: got %h required %h", got_fields(), exp_fields());
        else passed++;
    endtask

    task automatic test_random();
        cmd_t c;
        logic [63:0] t;
        logic [7:0] flags, op, x;
        int kind, nbits, total, w0, e0, want_err, want_wr;
        for (int it = 0; it < 6; it++) begin
            kind = $urandom_range(0, 4);
            c = rand_cmd(); t = {$urandom, $urandom}; flags = 8'($urandom);
            if (kind == 1) make_time(t, flags); else make_cmd(c);
            if (kind == 2) tx[tx.size() - 1] ^= 8'($urandom_range(1, 255));
            if (kind == 4) begin
                do op = 8'($urandom); while (op == 8'hA5 || op == 8'h5A);
                tx[0] = op;
            end
            total = tx.size() * 8;
            if (kind <= 1) for (int j = $urandom_range(0, 2); j > 0; j--) tx.push_back(8'($urandom));
            nbits = (kind == 3) ? $urandom_range(0, total - 1) : tx.size() * 8;
            x = 8'h00;
            for (int j = 0; j < total / 8; j++) x ^= tx[j];
            // Frame-level verdict: what the receiver must do with this frame as a whole.
            want_wr = 0;
            if (nbits == 0) want_err = 0;
            else if (nbits < 8) want_err = 1;
            else if (tx[0] != 8'hA5 && tx[0] != 8'h5A) want_err = 1;
            else if (nbits < total) want_err = 1;
            else if (x != 8'h00) want_err = 1;
            else begin
                want_err = 0;
                if (tx[0] == 8'hA5) begin exp_c = c; want_wr = 1; end
                else begin exp_time = t; exp_upd = flags[0]; end
            end
            w0 = wr_cnt; e0 = err_cnt;
            begin_frame(); send_bits(nbits); end_frame(12);
            checks++;
            if (err_cnt - e0 != want_err || wr_cnt - w0 != want_wr)
                $display("FAIL rand_pulses kind %0d: got err %0d wr %0d required %0d %0d",
                         kind, err_cnt - e0, wr_cnt - w0, want_err, want_wr);
            else passed++;
            checks++;
            if (got_fields() !== exp_fields())
                $display("FAIL rand_fields kind %0d: got %h required %h", kind, got_fields(), exp_fields());
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_cmd_frame();
        test_bad_checksum();
        test_time_frame();
        test_abort();
        test_unknown_opcode();
        test_reset_mid_frame();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
